mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/corePckg.sv | 45 ++++
 rtl/mem_lane_align.sv | 57 +++++
 rtl/mem_access.sv | 191 +++++++++++++++++++
 tb/tb_mem_access.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corePckg.sv
// Shared types for the memory-access stage: FSM states, load/store funct3 codes, pipeline payloads.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package corePckg;

    typedef enum logic [1:0] {
        eIdle   = 2'd0,
        eAccess = 2'd1,
        eWb     = 2'd2
    } tMemState;

    localparam logic [2:0] cLoadB  = 3'b000;
    localparam logic [2:0] cLoadH  = 3'b001;
    localparam logic [2:0] cLoadW  = 3'b010;
    localparam logic [2:0] cLoadBU = 3'b100;
    localparam logic [2:0] cLoadHU = 3'b101;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [2:0]  opType;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rdAddr;
    } tMemOp;

    typedef struct packed {
        logic        dv;
        logic [4:0]  addr;
        logic [31:0] data;
    } tRegOp;

    typedef struct packed {
        logic        dv;
        logic        taken;
        logic [31:0] target;
    } tBranchOp;

    typedef struct packed {
        tMemOp    memOp;
        tRegOp    regOp;
        tBranchOp brchOp;
    } tAluOut;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / lane replication and load extract with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; misalign flags a half/word access whose low address bits do not fit the size.
module mem_lane_align
    import corePckg::*;
(
    input  logic [2:0]  op_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_dat,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_dat,
    output logic        misalign
);

    logic [1:0]  off;
    logic [31:0] shifted;

    // Offset is aligned down to the access size so an unchecked misaligned access still hits whole lanes.
    always_comb begin
        off      = addr_lo;
        misalign = 1'b0;
        be       = 4'b1111;
        st_lanes = st_dat;
        case (op_type[1:0])
            2'b00: begin
                be       = 4'b0001 << addr_lo;
                st_lanes = {4{st_dat[7:0]}};
            end
            2'b01: begin
                off      = {addr_lo[1], 1'b0};
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_dat[15:0]}};
            end
            default: begin
                off      = 2'b00;
                misalign = |addr_lo;
            end
        endcase
    end

    assign shifted = ld_word >> {off, 3'b000};

    always_comb begin
        case (op_type)
            cLoadB:  ld_dat = {{24{shifted[7]}}, shifted[7:0]};
            cLoadBU: ld_dat = {24'd0, shifted[7:0]};
            cLoadH:  ld_dat = {{16{shifted[15]}}, shifted[15:0]};
            cLoadHU: ld_dat = {16'd0, shifted[15:0]};
            cLoadW:  ld_dat = shifted;
            default: ld_dat = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues loads/stores, writes back loads, passes register-only ops through (MEM_MISALIGN_CHK_EN enables misalign rejection).
// Latency: register-only op 1 cycle; load writeback 1 cycle after iMemAck; access aborts after cMemTimeout cycles without ack.
// Backpressure: oStall is high for the whole access/writeback; upstream holds iAluOut/iAluDv meanwhile.
module mem_access
    import corePckg::*;
#(
    parameter int cMemTimeout = 64
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  tAluOut      iAluOut,
    input  logic        iAluDv,
    output logic        oStall,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic [3:0]  oMemBe,
    input  logic        iMemAck,
    input  logic [31:0] iMemRData,
    output tRegOp       oRegOp,
    output tBranchOp    oBrchOp,
    output logic        oMemErr,
    output logic        oMisalign
);

`ifdef MEM_MISALIGN_CHK_EN
    localparam logic cChkEn = 1'b1;
`else
    localparam logic cChkEn = 1'b0;
`endif

    localparam logic [7:0] cTmoLast = 8'(cMemTimeout - 1);

    tMemState    state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  op_type_q, op_type_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [4:0]  rd_q, rd_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdat_q, mem_wdat_d;
    logic [3:0]  mem_be_q, mem_be_d;
    tRegOp       reg_op_q, reg_op_d;
    tBranchOp    brch_op_q, brch_op_d;
    logic        mem_err_q, mem_err_d;
    logic        misalign_q, misalign_d;

    logic        is_mem;
    logic [2:0]  la_op_type;
    logic [1:0]  la_addr_lo;
    logic [3:0]  la_be;
    logic [31:0] la_st_lanes;
    logic [31:0] la_ld_dat;
    logic        la_misalign;

    assign is_mem = iAluOut.memOp.read ^ iAluOut.memOp.write;

    // In eIdle the aligner sees the incoming op (store lanes); afterwards the captured op (load extract).
    assign la_op_type = (state_q == eIdle) ? iAluOut.memOp.opType    : op_type_q;
    assign la_addr_lo = (state_q == eIdle) ? iAluOut.memOp.addr[1:0] : addr_lo_q;

    mem_lane_align u_lane_align (
        .op_type  (la_op_type),
        .addr_lo  (la_addr_lo),
        .st_dat   (iAluOut.memOp.wdata),
        .ld_word  (iMemRData),
        .be       (la_be),
        .st_lanes (la_st_lanes),
        .ld_dat   (la_ld_dat),
        .misalign (la_misalign)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_type_d  = op_type_q;
        addr_lo_d  = addr_lo_q;
        rd_d       = rd_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_wdat_d = mem_wdat_q;
        mem_be_d   = mem_be_q;
        reg_op_d   = '0;
        brch_op_d  = brch_op_q;
        mem_err_d  = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            eIdle: begin
                if (iAluDv) begin
                    brch_op_d = iAluOut.brchOp;
                    if (is_mem && cChkEn && la_misalign) begin
                        misalign_d = 1'b1;
                    end else if (is_mem) begin
                        state_d    = eAccess;
                        cnt_d      = 8'd0;
                        op_type_d  = iAluOut.memOp.opType;
                        addr_lo_d  = iAluOut.memOp.addr[1:0];
                        rd_d       = iAluOut.memOp.rdAddr;
                        mem_req_d  = 1'b1;
                        mem_we_d   = iAluOut.memOp.write;
                        mem_addr_d = {iAluOut.memOp.addr[31:2], 2'b00};
                        mem_wdat_d = la_st_lanes;
                        mem_be_d   = la_be;
                    end else begin
                        reg_op_d = iAluOut.regOp;
                    end
                end
            end
            eAccess: begin
                if (iMemAck) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (mem_we_q) begin
                        state_d = eIdle;
                    end else begin
                        state_d = eWb;
                        // rd 0 is hardwired zero in the register file: never write it.
                        if (rd_q != 5'd0) begin
                            reg_op_d.dv   = 1'b1;
                            reg_op_d.addr = rd_q;
                            reg_op_d.data = la_ld_dat;
                        end
                    end
                end else if (cnt_q == cTmoLast) begin
                    mem_err_d = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = eIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            eWb: begin
                state_d = eIdle;
            end
            default: begin
                state_d = eIdle;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q    <= eIdle;
            cnt_q      <= '0;
            op_type_q  <= '0;
            addr_lo_q  <= '0;
            rd_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
            mem_be_q   <= '0;
            reg_op_q   <= '0;
            brch_op_q  <= '0;
            mem_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_type_q  <= op_type_d;
            addr_lo_q  <= addr_lo_d;
            rd_q       <= rd_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wdat_q <= mem_wdat_d;
            mem_be_q   <= mem_be_d;
            reg_op_q   <= reg_op_d;
            brch_op_q  <= brch_op_d;
            mem_err_q  <= mem_err_d;
            misalign_q <= misalign_d;
        end
    end

    assign oStall    = (state_q != eIdle);
    assign oMemReq   = mem_req_q;
    assign oMemWe    = mem_we_q;
    assign oMemAddr  = mem_addr_q;
    assign oMemWData = mem_wdat_q;
    assign oMemBe    = mem_be_q;
    assign oRegOp    = reg_op_q;
    assign oBrchOp   = brch_op_q;
    assign oMemErr   = mem_err_q;
    assign oMisalign = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: scoreboard of expected memory requests and writebacks, checked by a negedge monitor.
module tb_mem_access;
    import corePckg::*;

    logic        iClk = 1'b0;
    logic        iRstN = 1'b0;
    tAluOut      iAluOut;
    logic        iAluDv;
    logic        oStall;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [3:0]  oMemBe;
    logic        iMemAck;
    logic [31:0] iMemRData;
    tRegOp       oRegOp;
    tBranchOp    oBrchOp;
    logic        oMemErr;
    logic        oMisalign;

    mem_access #(.cMemTimeout(64)) dut (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iAluOut   (iAluOut),
        .iAluDv    (iAluDv),
        .oStall    (oStall),
        .oMemReq   (oMemReq),
        .oMemWe    (oMemWe),
        .oMemAddr  (oMemAddr),
        .oMemWData (oMemWData),
        .oMemBe    (oMemBe),
        .iMemAck   (iMemAck),
        .iMemRData (iMemRData),
        .oRegOp    (oRegOp),
        .oBrchOp   (oBrchOp),
        .oMemErr   (oMemErr),
        .oMisalign (oMisalign)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdat;
    } req_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [4:0]  rd_a;
        logic [31:0] rdat;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdat;
        logic        e_wb;
        logic [31:0] e_data;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    err_seen = 0;
    int    mis_seen = 0;
    int    req_cycles = 0;
    logic  req_prev = 1'b0;
    req_t  req_q[$];
    tRegOp wb_q[$];
    req_t  mon_req;
    tRegOp mon_wb;
    vec_t  vecs[10];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge iClk) begin
        if (oMemReq) req_cycles++;
        if (oMemErr) err_seen++;
        if (oMisalign) mis_seen++;
        if (oMemReq && !req_prev) begin
            if (req_q.size() == 0) begin
                chk("req_unexpected", 1, 0);
            end else begin
                mon_req = req_q.pop_front();
                chk("req_we",   oMemWe,    mon_req.we);
                chk("req_addr", oMemAddr,  mon_req.addr);
                chk("req_be",   oMemBe,    mon_req.be);
                chk("req_wdat", oMemWData, mon_req.wdat);
            end
        end
        req_prev = oMemReq;
        if (oRegOp.dv) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 1, 0);
            end else begin
                mon_wb = wb_q.pop_front();
                chk("wb_addr", oRegOp.addr, mon_wb.addr);
                chk("wb_data", oRegOp.data, mon_wb.data);
            end
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic issue(input tAluOut op);
        int guard = 0;
        while (oStall && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) chk("issue_timeout", 1, 0);
        iAluOut = op;
        iAluDv  = 1'b1;
        tick();
        iAluDv  = 1'b0;
    endtask

    task automatic respond(input int dly, input logic [31:0] rdat, input logic exp_wb);
        int guard = 0;
        while (!oMemReq && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            chk("req_timeout", 1, 0);
        end else begin
            repeat (dly) tick();
            chk("req_held", oMemReq, 1);
            iMemAck   = 1'b1;
            iMemRData = rdat;
            tick();
            iMemAck   = 1'b0;
            iMemRData = 32'd0;
            chk("wb_latency", oRegOp.dv, exp_wb);
            chk("req_drop", oMemReq, 0);
            tick();
            chk("wb_one_cycle", oRegOp.dv, 0);
            chk("stall_clear", oStall, 0);
        end
    endtask

    function automatic tAluOut mk_mem(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      input logic [4:0] rd_a, input logic [31:0] tgt);
        tAluOut op;
        op = '0;
        op.memOp.read   = rd;
        op.memOp.write  = wr;
        op.memOp.opType = f3;
        op.memOp.addr   = a;
        op.memOp.wdata  = wd;
        op.memOp.rdAddr = rd_a;
        op.brchOp       = '{dv: 1'b1, taken: tgt[0], target: tgt};
        return op;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tAluOut op;
        int     e0;
        int     r0;
        int     m0;

        //           rd    wr    f3      addr          wdat          rd_a   rdat          e_addr        e_be     e_wdat        e_wb  e_data
        vecs[0] = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd5,  32'h80FF_0000, 32'h0000_0100, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80};
        vecs[1] = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd0,  32'h0,        32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 3'b100, 32'h0000_0021, 32'h0,        5'd3,  32'h0000_A500, 32'h0000_0020, 4'b0010, 32'h0,        1'b1, 32'h0000_00A5};
        vecs[3] = '{1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'h0,        5'd9,  32'h0000_8001, 32'h0000_0010, 4'b0011, 32'h0,        1'b1, 32'hFFFF_8001};
        vecs[4] = '{1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'h0,        5'd10, 32'hBEEF_1234, 32'h0000_0010, 4'b1100, 32'h0,        1'b1, 32'h0000_BEEF};
        vecs[5] = '{1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0,        5'd31, 32'hDEAD_BEEF, 32'h0000_0040, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 1'b1, 3'b000, 32'h0000_0033, 32'h0000_0077, 5'd0,  32'h0,        32'h0000_0030, 4'b1000, 32'h7777_7777, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 5'd0,  32'h0,        32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 3'b010, 32'h0000_0050, 32'h0,        5'd0,  32'h1234_5678, 32'h0000_0050, 4'b1111, 32'h0,        1'b0, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        5'd1,  32'h0000_007F, 32'h0000_0100, 4'b0001, 32'h0,        1'b1, 32'h0000_007F};

        iAluOut   = '0;
        iAluDv    = 1'b0;
        iMemAck   = 1'b0;
        iMemRData = 32'd0;

        repeat (3) tick();
        chk("rst_stall",  oStall,   0);
        chk("rst_req",    oMemReq,  0);
        chk("rst_we",     oMemWe,   0);
        chk("rst_addr",   oMemAddr, 0);
        chk("rst_be",     oMemBe,   0);
        chk("rst_regop",  oRegOp,   0);
        chk("rst_brch",   oBrchOp,  0);
        chk("rst_err",    oMemErr,  0);
        chk("rst_mis",    oMisalign, 0);
        iRstN = 1'b1;
        tick();

        // Register-only op: writeback the next cycle, no stall, no memory traffic.
        op = '0;
        op.regOp  = '{dv: 1'b1, addr: 5'd7, data: 32'h55};
        op.brchOp = '{dv: 1'b1, taken: 1'b1, target: 32'h1000};
        wb_q.push_back(op.regOp);
        issue(op);
        chk("reg_dv",     oRegOp.dv, 1);
        chk("reg_stall",  oStall, 0);
        chk("reg_memreq", oMemReq, 0);
        chk("reg_brch",   oBrchOp, {1'b1, 1'b1, 32'h1000});
        tick();
        chk("reg_dv_drop", oRegOp.dv, 0);
        chk("reg_memreq2", oMemReq, 0);

        for (int i = 0; i < 10; i++) begin
            op = mk_mem(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdat,
                        vecs[i].rd_a, 32'h2000 + 32'(i));
            req_q.push_back('{we: vecs[i].wr, addr: vecs[i].e_addr, be: vecs[i].e_be, wdat: vecs[i].e_wdat});
            if (vecs[i].e_wb) wb_q.push_back('{dv: 1'b1, addr: vecs[i].rd_a, data: vecs[i].e_data});
            issue(op);
            chk("acc_stall", oStall, 1);
            respond(i % 4, vecs[i].rdat, vecs[i].e_wb);
            chk("brch_hold", oBrchOp, {1'b1, 1'(i), 32'h2000 + 32'(i)});
        end

        // Read and write both set: no memory access, register op path.
        op = mk_mem(1'b1, 1'b1, 3'b010, 32'h60, 32'h0, 5'd2, 32'h3000);
        op.regOp = '{dv: 1'b1, addr: 5'd12, data: 32'hA5A5};
        wb_q.push_back(op.regOp);
        issue(op);
        chk("rw_dv",     oRegOp.dv, 1);
        chk("rw_memreq", oMemReq, 0);
        chk("rw_stall",  oStall, 0);
        tick();

        // Timeout: no ack ever arrives.
        e0 = err_seen;
        r0 = req_cycles;
        req_q.push_back('{we: 1'b0, addr: 32'h80, be: 4'b1111, wdat: 32'h0});
        issue(mk_mem(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 5'd4, 32'h4000));
        repeat (80) tick();
        chk("tmo_err_pulses", err_seen - e0, 1);
        chk("tmo_req_cycles", req_cycles - r0, 64);
        chk("tmo_req_drop",   oMemReq, 0);
        chk("tmo_stall",      oStall, 0);

        // Reset in the middle of an access.
        req_q.push_back('{we: 1'b0, addr: 32'h90, be: 4'b1111, wdat: 32'h0});
        issue(mk_mem(1'b1, 1'b0, 3'b010, 32'h90, 32'h0, 5'd6, 32'h5000));
        tick();
        chk("mid_stall_before", oStall, 1);
        iRstN = 1'b0;
        #1;
        chk("mid_rst_stall", oStall, 0);
        chk("mid_rst_req",   oMemReq, 0);
        chk("mid_rst_addr",  oMemAddr, 0);
        chk("mid_rst_be",    oMemBe, 0);
        chk("mid_rst_brch",  oBrchOp, 0);
        chk("mid_rst_regop", oRegOp, 0);
        tick();
        iRstN = 1'b1;
        tick();
        op = '0;
        op.regOp = '{dv: 1'b1, addr: 5'd8, data: 32'h99};
        wb_q.push_back(op.regOp);
        issue(op);
        chk("post_rst_dv", oRegOp.dv, 1);
        tick();

        // Word access at a non-word address.
        m0 = mis_seen;
`ifdef MEM_MISALIGN_CHK_EN
        issue(mk_mem(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd11, 32'h6000));
        chk("mis_req",   oMemReq, 0);
        chk("mis_stall", oStall, 0);
        tick();
        tick();
        chk("mis_pulse", mis_seen - m0, 1);
`else
        req_q.push_back('{we: 1'b0, addr: 32'h4, be: 4'b1111, wdat: 32'h0});
        wb_q.push_back('{dv: 1'b1, addr: 5'd11, data: 32'h1122_3344});
        issue(mk_mem(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd11, 32'h6000));
        respond(1, 32'h1122_3344, 1'b1);
        chk("mis_tied", mis_seen - m0, 0);
`endif

        repeat (3) tick();
        chk("wb_left",  wb_q.size(), 0);
        chk("req_left", req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
